// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: derives the ALU op and operand b from RISC-V fields
// and holds issued operands in a main register backed by a one-entry skid register.
module alu_issue_stage #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_opcode,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [W-1:0]  in_rs1,
  input  logic [W-1:0]  in_rs2,
  input  logic [W-1:0]  in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_op,
  output logic          out_illegal,
  output logic [CW-1:0] issue_count
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         ill;
  } entry_t;

  // Valid/ready: a beat moves on a rising edge only when valid and ready are both
  // high; in_ready depends on registered state (and rst) only, never on out_ready.

  entry_t          dec;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_acc, out_acc;

  always_comb begin
    dec     = '{a: in_rs1, b: in_rs2, op: OP_ADD, ill: 1'b0};
    case (in_opcode)
      7'b0110011: begin
        case (in_funct3)
          3'b000:  dec.op = in_funct7b5 ? OP_SUB : OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: dec.ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.b = in_imm;
        case (in_funct3)
          3'b000:  dec.op = OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: begin
            // Unsupported I-type encodings fall back to the generic illegal form.
            dec.b   = in_rs2;
            dec.ill = 1'b1;
          end
        endcase
      end
      7'b0000011, 7'b0100011: dec.b = in_imm;
      7'b1100011:             dec.op = OP_SUB;
      default:                dec.ill = 1'b1;
    endcase
  end

  assign in_ready = !rst && !skid_valid_q;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    count_d      = out_acc ? count_q + 1'b1 : count_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_acc) begin
      // Main is free at this edge: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_acc) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_acc) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_op      = main_q.op;
  assign out_illegal = main_q.ill;
  assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic checked against
// a FIFO-of-decoded-entries reference model.
module tb_alu_issue_stage;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk, rst, flush, in_valid, in_ready, in_funct7b5;
  logic [6:0]    in_opcode;
  logic [2:0]    in_funct3;
  logic [W-1:0]  in_rs1, in_rs2, in_imm;
  logic          out_valid, out_ready, out_illegal;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [CW-1:0] issue_count;

  alu_issue_stage #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_illegal(out_illegal),
    .issue_count(issue_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         ill;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_checks, n_errors;

  function automatic exp_t ref_decode(logic [6:0] opc, logic [2:0] f3, logic f7,
                                      logic [W-1:0] rs1, logic [W-1:0] rs2, logic [W-1:0] imm);
    exp_t e;
    e.a = rs1; e.b = rs2; e.op = 3'b010; e.ill = 1'b0;
    if (opc == 7'b0110011) begin
      if (f3 == 3'b000) e.op = f7 ? 3'b110 : 3'b010;
      else if (f3 == 3'b111) e.op = 3'b000;
      else if (f3 == 3'b110) e.op = 3'b001;
      else if (f3 == 3'b010) e.op = 3'b111;
      else e.ill = 1'b1;
    end else if (opc == 7'b0010011) begin
      if (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010) begin
        e.b  = imm;
        e.op = (f3 == 3'b000) ? 3'b010 : (f3 == 3'b111) ? 3'b000 :
               (f3 == 3'b110) ? 3'b001 : 3'b111;
      end else e.ill = 1'b1;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) e.b = imm;
    else if (opc == 7'b1100011) e.op = 3'b110;
    else e.ill = 1'b1;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle();
    bit ia, oa;
    @(posedge clk);
    ia = in_valid && !rst && exp_q.size() < 2;
    oa = out_ready && exp_q.size() > 0;
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (flush) begin
      if (oa) exp_cnt++;
      exp_q.delete();
    end else begin
      if (oa) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (ia) exp_q.push_back(ref_decode(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm));
    end
    #1;
  endtask

  task automatic set_beat(logic [6:0] opc, logic [2:0] f3, logic f7,
                          logic [W-1:0] rs1, logic [W-1:0] rs2, logic [W-1:0] imm);
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    cycle();
    cycle();
    n_checks++;
    if ({out_valid, in_ready, alu_op, out_illegal} !== 6'b0 || alu_a !== '0 || alu_b !== '0 || issue_count !== '0) begin
      n_errors++;
      $display("FAIL reset_state: v=%b rdy=%b op=%b ill=%b a=%h b=%h cnt=%0d, want all zero",
               out_valid, in_ready, alu_op, out_illegal, alu_a, alu_b, issue_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  typedef struct packed {
    logic [6:0] opc; logic [2:0] f3; logic f7;
    logic [W-1:0] rs1, rs2, imm;
    logic [2:0] op; logic [W-1:0] b; logic ill;
  } vec_t;

  task automatic test_decode();
    vec_t tbl[13];
    tbl = '{
      '{7'h33, 3'd0, 1'b0, 32'd7,    32'd5,  32'd0,        3'b010, 32'd5,        1'b0},
      '{7'h33, 3'd0, 1'b1, 32'd7,    32'd5,  32'd0,        3'b110, 32'd5,        1'b0},
      '{7'h13, 3'd0, 1'b0, 32'h10,   32'hAA, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF, 1'b0},
      '{7'h63, 3'd0, 1'b0, 32'h10,   32'd3,  32'h44,       3'b110, 32'd3,        1'b0},
      '{7'h7F, 3'd0, 1'b0, 32'd1,    32'd2,  32'd3,        3'b010, 32'd2,        1'b1},
      '{7'h13, 3'd7, 1'b1, 32'd1,    32'd2,  32'd3,        3'b000, 32'd3,        1'b0},
      '{7'h33, 3'd6, 1'b0, 32'd11,   32'd12, 32'd13,       3'b001, 32'd12,       1'b0},
      '{7'h33, 3'd2, 1'b0, 32'd21,   32'd22, 32'd23,       3'b111, 32'd22,       1'b0},
      '{7'h03, 3'd5, 1'b1, 32'd31,   32'd32, 32'd33,       3'b010, 32'd33,       1'b0},
      '{7'h23, 3'd2, 1'b0, 32'd41,   32'd42, 32'd43,       3'b010, 32'd43,       1'b0},
      '{7'h33, 3'd1, 1'b0, 32'd51,   32'd52, 32'd53,       3'b010, 32'd52,       1'b1},
      '{7'h13, 3'd1, 1'b0, 32'd61,   32'd62, 32'd63,       3'b010, 32'd62,       1'b1},
      '{7'h13, 3'd2, 1'b0, 32'd71,   32'd72, 32'd73,       3'b111, 32'd73,       1'b0}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_beat(tbl[i].opc, tbl[i].f3, tbl[i].f7, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || alu_op !== tbl[i].op || alu_a !== tbl[i].rs1 ||
          alu_b !== tbl[i].b || out_illegal !== tbl[i].ill) begin
        n_errors++;
        $display("FAIL decode[%0d]: v=%b op=%b a=%h b=%h ill=%b, want v=1 op=%b a=%h b=%h ill=%b",
                 i, out_valid, alu_op, alu_a, alu_b, out_illegal, tbl[i].op, tbl[i].rs1, tbl[i].b, tbl[i].ill);
      end
    end
    in_valid = 1'b0;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || issue_count !== exp_cnt || exp_cnt !== CW'(13)) begin
      n_errors++;
      $display("FAIL decode_drain: v=%b cnt=%0d, want v=0 cnt=%0d (13)", out_valid, issue_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(7'h33, 3'd0, 1'b0, 32'd1, 32'd100, 32'd0); cycle();
    set_beat(7'h33, 3'd0, 1'b0, 32'd2, 32'd100, 32'd0); cycle();
    set_beat(7'h33, 3'd0, 1'b0, 32'd3, 32'd100, 32'd0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 32'd1) begin
      n_errors++;
      $display("FAIL bp_full: rdy=%b v=%b a=%0d, want rdy=0 v=1 a=1", in_ready, out_valid, alu_a);
    end
    cycle();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 32'd1 || alu_b !== 32'd100) begin
      n_errors++;
      $display("FAIL bp_hold: rdy=%b v=%b a=%0d b=%0d, want rdy=0 v=1 a=1 b=100", in_ready, out_valid, alu_a, alu_b);
    end
    out_ready = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      cycle();
      if (k == 3) in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || alu_a !== 32'(k)) begin
        n_errors++;
        $display("FAIL bp_order[%0d]: v=%b a=%0d, want v=1 a=%0d", k, out_valid, alu_a, k);
      end
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
      n_errors++;
      $display("FAIL bp_end: v=%b cnt=%0d, want v=0 cnt=%0d", out_valid, issue_count, exp_cnt);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] cnt_before;
    out_ready = 1'b0;
    set_beat(7'h13, 3'd0, 1'b0, 32'd9, 32'd0, 32'd1); cycle();
    set_beat(7'h13, 3'd0, 1'b0, 32'd8, 32'd0, 32'd1); cycle();
    cnt_before = exp_cnt;
    set_beat(7'h13, 3'd0, 1'b0, 32'd7, 32'd0, 32'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || issue_count !== cnt_before) begin
      n_errors++;
      $display("FAIL flush_state: v=%b rdy=%b cnt=%0d, want v=0 rdy=1 cnt=%0d", out_valid, in_ready, issue_count, cnt_before);
    end
    out_ready = 1'b1;
    cycle(); cycle();
    n_checks++;
    if (out_valid !== 1'b0 || issue_count !== cnt_before) begin
      n_errors++;
      $display("FAIL flush_gone: v=%b cnt=%0d, want v=0 cnt=%0d", out_valid, issue_count, cnt_before);
    end
  endtask

  task automatic test_wrap();
    int hs;
    do_reset();
    hs = 0;
    out_ready = 1'b1;
    set_beat(7'h7F, 3'd0, 1'b0, 32'd5, 32'd6, 32'd7);
    for (int c = 0; c < 4 * (1 << CW) && hs < (1 << CW) + 1; c++) begin
      if (out_valid && out_ready) hs++;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (hs !== (1 << CW) + 1 || issue_count !== CW'(1)) begin
      n_errors++;
      $display("FAIL wrap: handshakes=%0d cnt=%0d, want handshakes=%0d cnt=1", hs, issue_count, (1 << CW) + 1);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || alu_op !== 3'b010 || alu_b !== 32'd6) begin
      n_errors++;
      $display("FAIL wrap_illegal: v=%b ill=%b op=%b b=%0d, want v=1 ill=1 op=010 b=6", out_valid, out_illegal, alu_op, alu_b);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    set_beat(7'h33, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0); cycle();
    cycle();
    out_ready = 1'b0; cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_ready: in_ready=%b want 0", in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || issue_count !== '0 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_state: v=%b cnt=%0d rdy=%b, want v=0 cnt=0 rdy=0", out_valid, issue_count, in_ready);
    end
    rst = 1'b0;
    cycle();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_after: rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs[7];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h00};
    for (int c = 0; c < 600; c++) begin
      set_beat(opcs[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      if (in_opcode == 7'h00) in_opcode = 7'($urandom);
      #1;
      n_checks++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (!rst && exp_q.size() < 2) ||
          issue_count !== exp_cnt) begin
        n_errors++;
        $display("FAIL rand_ctl[%0d]: v=%b rdy=%b cnt=%0d, want v=%b rdy=%b cnt=%0d", c, out_valid, in_ready,
                 issue_count, exp_q.size() > 0, !rst && exp_q.size() < 2, exp_cnt);
      end else if (exp_q.size() > 0) begin
        n_checks++;
        if (alu_a !== exp_q[0].a || alu_b !== exp_q[0].b || alu_op !== exp_q[0].op || out_illegal !== exp_q[0].ill) begin
          n_errors++;
          $display("FAIL rand_data[%0d]: a=%h b=%h op=%b ill=%b, want a=%h b=%h op=%b ill=%b", c, alu_a, alu_b,
                   alu_op, out_illegal, exp_q[0].a, exp_q[0].b, exp_q[0].op, exp_q[0].ill);
        end
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = '0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
